// File: rtl/add32_seq.sv
// add32_seq: two-cycle 32-bit add/subtract sequencer reusing one 16-bit CLA-ripple adder.
// Optional flags (ovf, zero) are enabled by defining ADD32_SEQ_FLAGS_EN.

module CLA_16bit_ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        carry
);
    logic [4:0] c;
    assign c[0] = cin;
    assign carry = c[4];
    genvar g;
    for (g = 0; g < 4; g++) begin : grp
        logic [3:0] p, k, cc;
        assign p = a[4*g +: 4] ^ b[4*g +: 4];
        assign k = a[4*g +: 4] & b[4*g +: 4];
        assign cc[0] = c[g];
        assign cc[1] = k[0] | (p[0] & cc[0]);
        assign cc[2] = k[1] | (p[1] & k[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = k[2] | (p[2] & k[1]) | (p[2] & p[1] & k[0]) | (p[2] & p[1] & p[0] & cc[0]);
        assign c[g+1] = k[3] | (p[3] & k[2]) | (p[3] & p[2] & k[1]) | (p[3] & p[2] & p[1] & k[0])
                      | (&p & cc[0]);
        assign s[4*g +: 4] = p ^ cc;
    end
endmodule

module add32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
`ifdef ADD32_SEQ_FLAGS_EN
    output logic        ovf,
    output logic        zero,
`endif
    output logic        cout
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
    logic [15:0] lo_q, lo_d, add_a, add_b, add_s;
    logic        cin_q, cin_d, c16_q, c16_d, cout_q, cout_d, add_ci, add_c, accept;
`ifdef ADD32_SEQ_FLAGS_EN
    logic        ovf_q, ovf_d, zero_q, zero_d;
    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == LO) || (state_q == HI);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

    CLA_16bit_ripple u_cla (.a(add_a), .b(add_b), .cin(add_ci), .s(add_s), .carry(add_c));

    // Adder input mux: high half in HI, low half otherwise; next-state and datapath updates
    always_comb begin
        add_a   = (state_q == HI) ? opa_q[31:16] : opa_q[15:0];
        add_b   = (state_q == HI) ? opb_q[31:16] : opb_q[15:0];
        add_ci  = (state_q == HI) ? c16_q : cin_q;
        accept  = start && ready;
        state_d = accept ? LO : (state_q == LO) ? HI : (state_q == HI) ? DONE : IDLE;
        opa_d   = accept ? a : opa_q;
        opb_d   = accept ? (b ^ {32{sub}}) : opb_q;
        cin_d   = accept ? sub : cin_q;
        lo_d    = (state_q == LO) ? add_s : lo_q;
        c16_d   = (state_q == LO) ? add_c : c16_q;
        sum_d   = (state_q == HI) ? {add_s, lo_q} : sum_q;
        cout_d  = (state_q == HI) ? add_c : cout_q;
`ifdef ADD32_SEQ_FLAGS_EN
        ovf_d   = (state_q == HI) ? ((opa_q[31] == opb_q[31]) && (add_s[15] != opa_q[31])) : ovf_q;
        zero_d  = (state_q == HI) ? ({add_s, lo_q} == '0) : zero_q;
`endif
    end

    // All state and result registers; async reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            lo_q    <= '0;
            c16_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD32_SEQ_FLAGS_EN
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cin_q   <= cin_d;
            lo_q    <= lo_d;
            c16_q   <= c16_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADD32_SEQ_FLAGS_EN
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`endif
        end
    end
endmodule

// File: tb/tb_add32_seq.sv
// tb_add32_seq: randomized and directed checks of add32_seq against an arithmetic reference model.

module tb_add32_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, busy, done, cout;
    logic [31:0] sum;
`ifdef ADD32_SEQ_FLAGS_EN
    logic        ovf, zero;
`endif
    int checks = 0;
    int errors = 0;

    add32_seq dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .sum(sum),
`ifdef ADD32_SEQ_FLAGS_EN
        .ovf(ovf), .zero(zero),
`endif
        .cout(cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic, no bit-level adder modelling.
    function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y, input logic s);
        return s ? x - y : x + y;
    endfunction

    function automatic logic ref_cout(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint unsigned t;
        t = longint'(x) + longint'(y);
        return s ? (x >= y) : (t > 64'hFFFF_FFFF);
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint r;
        r = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s);
        check({tag, "_sum"}, {1'b0, sum}, {1'b0, ref_sum(x, y, s)});
        check({tag, "_cout"}, {32'b0, cout}, {32'b0, ref_cout(x, y, s)});
`ifdef ADD32_SEQ_FLAGS_EN
        check({tag, "_ovf"}, {32'b0, ovf}, {32'b0, ref_ovf(x, y, s)});
        check({tag, "_zero"}, {32'b0, zero}, {32'b0, ref_sum(x, y, s) == 32'h0});
`endif
    endtask

    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s);
        int lat;
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 33'(lat), 33'd3);
        check({tag, "_ready"}, {32'b0, ready}, 33'd1);
        check({tag, "_busy"}, {32'b0, busy}, 33'd0);
        check_result(tag, x, y, s);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        #3;
        check("rst_sum", {1'b0, sum}, 33'd0);
        check("rst_cout", {32'b0, cout}, 33'd0);
        check("rst_ready", {32'b0, ready}, 33'd1);
        check("rst_busy", {32'b0, busy}, 33'd0);
        check("rst_done", {32'b0, done}, 33'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("carry16", 32'h0000FFFF, 32'h00000001, 1'b0);
        do_op("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0);
        do_op("sub_neg", 32'd5, 32'd7, 1'b1);
        do_op("sub_pos", 32'd7, 32'd5, 1'b1);
        do_op("ovf_add", 32'h7FFFFFFF, 32'd1, 1'b0);
        do_op("ovf_sub", 32'h80000000, 32'd1, 1'b1);
        do_op("sub_eq", 32'h12345678, 32'h12345678, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
            if (i % 8 == 0) rb = ra;
            do_op("rand", ra, rb, rs);
        end

        // start held high: a done pulse every third cycle with fresh operands each time
        @(negedge clk);
        a = $urandom; b = $urandom; sub = 1'($urandom_range(1)); start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ra = a; rb = b; rs = sub;
            for (int i = 1; i <= 3; i++) begin
                @(negedge clk);
                check("b2b_done", {32'b0, done}, {32'b0, i == 3});
            end
            check_result("b2b", ra, rb, rs);
            if (k == 4) start = 1'b0;
            else begin
                a = $urandom; b = $urandom; sub = 1'($urandom_range(1));
            end
        end
        @(negedge clk);
        check("b2b_idle_ready", {32'b0, ready}, 33'd1);

        // start in LO is ignored
        @(negedge clk);
        ra = 32'hA5A50F0F; rb = 32'h0102F0F1;
        a = ra; b = rb; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        check("ign_busy", {32'b0, busy}, 33'd1);
        check("ign_ready", {32'b0, ready}, 33'd0);
        a = 32'd1; b = 32'd1; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_hi_done", {32'b0, done}, 33'd0);
        @(negedge clk);
        check("ign_done", {32'b0, done}, 33'd1);
        check_result("ign", ra, rb, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ign_no_done", {32'b0, done}, 33'd0);
            check("ign_hold", {1'b0, sum}, {1'b0, ref_sum(ra, rb, 1'b0)});
        end

        // async reset while in HI aborts the operation
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sum", {1'b0, sum}, 33'd0);
        check("arst_cout", {32'b0, cout}, 33'd0);
        check("arst_ready", {32'b0, ready}, 33'd1);
        check("arst_busy", {32'b0, busy}, 33'd0);
        check("arst_done", {32'b0, done}, 33'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_done", {32'b0, done}, 33'd0);
        end
        do_op("post_rst", 32'hDEADBEEF, 32'h01234567, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
